debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- UART-side control unit placed between the byte-level UART rx/tx cores and the pipelined MIPS core.
- Loads the program into instruction memory and gates the core clock enable for continuous or single-step execution.
- After each run or step, streams a state dump of PC, register file and a data-memory window back to the host.
- Replaces ad-hoc loader logic. Depths, word count and dump window are parameters.

Parameters:
SIZE, 32, datapath/word width in bits (multiple of 8).
MAX_INSTRUCTION, 64, instruction memory depth in words.
NUM_REGISTERS, 32, register-file entries dumped.
DUMP_WORDS, 16, data-memory words dumped, starting at address 0.
IMEM_ADDR_W, $clog2(MAX_INSTRUCTION), instruction address width.
REG_ADDR_W, $clog2(NUM_REGISTERS), register address width.
DMEM_ADDR_W, $clog2(DUMP_WORDS), dump window address width.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_done  in  1  1-cycle strobe; i_rx_data valid
o_tx_data  out  8  byte to send
o_tx_start  out  1  1-cycle request to send o_tx_data
i_tx_done  in  1  1-cycle strobe; previous byte sent
o_imem_we  out  1  instruction memory write enable
o_imem_addr  out  IMEM_ADDR_W  write address
o_imem_data  out  SIZE  write word
o_cpu_en  out  1  core clock enable (pipeline advances when 1)
o_cpu_rst  out  1  synchronous core reset pulse, issued after load
i_halt  in  1  core reached HALT instruction (level)
i_pc  in  SIZE  current PC
o_reg_addr  out  REG_ADDR_W  register read address (combinational read)
i_reg_data  in  SIZE  register read data
o_mem_addr  out  DMEM_ADDR_W  data-memory read address (1-cycle read latency)
i_mem_data  in  SIZE  data-memory read data
o_state  out  4  current FSM state, for debug LEDs

Behaviour:
- Reset values (i_rst=0, asynchronous): all outputs 0; FSM in IDLE; counters 0. Reset mid-transfer abandons the transfer. No partial byte is emitted after reset release.
- Commands are single bytes, accepted in IDLE only:
  - 0x4C 'L': load
  - 0x43 'C': continuous run
  - 0x53 'S': single step
  - 0x44 'D': dump only
  - Any other byte: send 0xEE, stay in IDLE.
- Load sequence:
  - LOAD_CNT: next byte is N. N=0 or N>MAX_INSTRUCTION -> send 0xEE, return to IDLE.
  - LOAD_DATA: receive 4*N bytes (SIZE/8 per word), little-endian.
  - On the last byte of each word: o_imem_we=1 for exactly one cycle, with o_imem_addr = word index and o_imem_data = the assembled word.
  - After word N: pulse o_cpu_rst for one cycle, send ack 0x4B, return to IDLE.
- Run: RUN holds o_cpu_en=1 until i_halt=1 is sampled. o_cpu_en drops the same cycle halt is seen (registered; the core runs at most one extra cycle). Then go to DUMP.
- Step: STEP drives o_cpu_en=1 for exactly one cycle, then goes to DUMP. If i_halt is already 1, no enable is issued; go to DUMP directly.
- 'D': go straight to DUMP.
- Dump order:
  1. PC, 4 bytes, LSB first.
  2. Registers 0..NUM_REGISTERS-1, 4 bytes each, LSB first.
  3. Memory words 0..DUMP_WORDS-1, 4 bytes each, LSB first.
- Total dump length = 4*(1+NUM_REGISTERS+DUMP_WORDS) bytes; default 196.
- Memory words are latched one cycle after o_mem_addr changes.
- Words are latched into a shift register before their first byte is sent.
- TX handshake: one o_tx_start pulse per byte. The next pulse is issued no earlier than the cycle after i_tx_done. o_tx_data is held stable from o_tx_start until i_tx_done.
- RX bytes arriving during RUN, STEP or DUMP are discarded.
- A host byte arriving in the same cycle as i_halt is discarded.
- FSM states (o_state encoding): IDLE=0, LOAD_CNT=1, LOAD_DATA=2, LOAD_ACK=3, RUN=4, STEP=5, DUMP_LATCH=6, DUMP_SEND=7, DUMP_WAIT=8, ERR=9.
- Counters:
  - Byte counter wraps 0..3.
  - Word counter saturates at its terminal value; never wraps past N or the dump length.

Optional Feature:
- Macro: DEBUG_UNIT_CKSUM_EN.
- Defined:
  - An 8-bit XOR of all dump bytes is appended as a final byte.
  - Load expects one extra byte after the 4*N data bytes, equal to the XOR of those data bytes.
  - On mismatch: send 0xEE instead of 0x4B and do not pulse o_cpu_rst. Words already written stay written.
- Undefined: no checksum byte in either direction; dump length as stated above.

Test Plan:
- Load 'L',0x02, bytes 20 00 01 24, FF FF FF FF -> imem[0]=0x24010020, imem[1]=0xFFFFFFFF; two single-cycle we pulses; o_cpu_rst pulse; tx 0x4B.
- 'L',0x00 and 'L',0x41 (MAX_INSTRUCTION=64) -> tx 0xEE each time, no imem write, FSM back to IDLE.
- 'S' with i_pc=0x4, reg1=0x20, mem0=0xDEADBEEF -> exactly one o_cpu_en cycle; 196 bytes; bytes 0-3 = 04 00 00 00; bytes 8-11 = 20 00 00 00; bytes 132-135 = EF BE AD DE.
- 'C', i_halt raised after 10 cycles -> o_cpu_en high for 10 or 11 cycles, then full dump; 0x51 received during dump is ignored.
- Unknown byte 0x7A -> single tx 0xEE; assert i_rst low mid-dump -> o_tx_start=0 at once, o_state=0, next 'D' gives a full 196-byte dump.
- With DEBUG_UNIT_CKSUM_EN: wrong load checksum -> 0xEE, no o_cpu_rst; 'D' -> 197 bytes, last byte = XOR of the first 196.

Source files
------------

// File: rtl/debug_unit.sv
// debug_unit: UART-side control unit for the pipelined MIPS core.
// It loads instruction memory from the host and gates the core clock enable for
// continuous or single-step execution. After each run, step or 'D' command it
// streams back a dump of the PC, the register file and a data-memory window.
// Optional feature macro: DEBUG_UNIT_CKSUM_EN. When it is defined, the load
// stream ends with an XOR checksum byte, and the dump stream gets one appended.
module debug_unit #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int NUM_REGISTERS   = 32,
  parameter int DUMP_WORDS      = 16,
  parameter int IMEM_ADDR_W     = $clog2(MAX_INSTRUCTION),
  parameter int REG_ADDR_W      = $clog2(NUM_REGISTERS),
  parameter int DMEM_ADDR_W     = $clog2(DUMP_WORDS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_cpu_en,
  output logic                   o_cpu_rst,
  input  logic                   i_halt,
  input  logic [SIZE-1:0]        i_pc,
  output logic [REG_ADDR_W-1:0]  o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  output logic [DMEM_ADDR_W-1:0] o_mem_addr,
  input  logic [SIZE-1:0]        i_mem_data,
  output logic [3:0]             o_state
);

  localparam int BPW         = SIZE / 8;
  localparam int BCW         = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TOTAL_WORDS = 1 + NUM_REGISTERS + DUMP_WORDS;
  localparam int WMAX        = (TOTAL_WORDS > MAX_INSTRUCTION) ? TOTAL_WORDS : MAX_INSTRUCTION;
  localparam int WCW         = $clog2(WMAX + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_CNT   = 4'd1,
    LOAD_DATA  = 4'd2,
    LOAD_ACK   = 4'd3,
    RUN        = 4'd4,
    STEP       = 4'd5,
    DUMP_LATCH = 4'd6,
    DUMP_SEND  = 4'd7,
    DUMP_WAIT  = 4'd8,
    ERR        = 4'd9
  } state_e;

  state_e                 state_q, state_d;
  logic [BCW-1:0]         byte_q, byte_d;
  logic [WCW-1:0]         word_q, word_d;
  logic [WCW-1:0]         n_q, n_d;
  logic [SIZE-1:0]        shift_q, shift_d;
  logic                   tx_busy_q, tx_busy_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]        imem_data_q, imem_data_d;
  logic                   cpu_en_q, cpu_en_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic [REG_ADDR_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DMEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                   enter_dump;
  logic [31:0]            nxt_w;
`ifdef DEBUG_UNIT_CKSUM_EN
  logic [7:0]             cks_q, cks_d;
  logic                   cks_phase_q, cks_phase_d;
`endif

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    word_d      = word_q;
    n_d         = n_q;
    shift_d     = shift_q;
    tx_busy_d   = tx_busy_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    cpu_en_d    = 1'b0;
    cpu_rst_d   = 1'b0;
    reg_addr_d  = reg_addr_q;
    mem_addr_d  = mem_addr_q;
    enter_dump  = 1'b0;
    nxt_w       = 32'(word_q) + 32'd1;
`ifdef DEBUG_UNIT_CKSUM_EN
    cks_d       = cks_q;
    cks_phase_d = cks_phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            8'h4C: begin
              state_d = LOAD_CNT;
              byte_d  = '0;
              word_d  = '0;
`ifdef DEBUG_UNIT_CKSUM_EN
              cks_d       = 8'h00;
              cks_phase_d = 1'b0;
`endif
            end
            8'h43: begin
              state_d  = RUN;
              cpu_en_d = 1'b1;
            end
            8'h53: begin
              // A halted core is not stepped; the host still gets a dump.
              if (i_halt) begin
                enter_dump = 1'b1;
              end else begin
                state_d  = STEP;
                cpu_en_d = 1'b1;
              end
            end
            8'h44:   enter_dump = 1'b1;
            default: state_d = ERR;
          endcase
        end
      end
      LOAD_CNT: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'd0 || 32'(i_rx_data) > 32'(MAX_INSTRUCTION)) begin
            state_d = ERR;
          end else begin
            n_d     = WCW'(i_rx_data);
            state_d = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (i_rx_done) begin
`ifdef DEBUG_UNIT_CKSUM_EN
          if (cks_phase_q) begin
            state_d = (i_rx_data == cks_q) ? LOAD_ACK : ERR;
          end else
`endif
          begin
            // Bytes arrive LSB first, so shift each new byte in from the top.
            shift_d = {i_rx_data, shift_q[SIZE-1:8]};
`ifdef DEBUG_UNIT_CKSUM_EN
            cks_d = cks_q ^ i_rx_data;
`endif
            if (byte_q == BCW'(BPW - 1)) begin
              byte_d      = '0;
              imem_we_d   = 1'b1;
              imem_addr_d = IMEM_ADDR_W'(word_q);
              imem_data_d = {i_rx_data, shift_q[SIZE-1:8]};
              if (word_q == n_q - WCW'(1)) begin
`ifdef DEBUG_UNIT_CKSUM_EN
                cks_phase_d = 1'b1;
`else
                state_d = LOAD_ACK;
`endif
              end else begin
                word_d = word_q + WCW'(1);
              end
            end else begin
              byte_d = byte_q + BCW'(1);
            end
          end
        end
      end
      LOAD_ACK, ERR: begin
        // Single-byte reply; the core reset pulse accompanies a successful ack.
        if (!tx_busy_q) begin
          tx_start_d = 1'b1;
          tx_busy_d  = 1'b1;
          tx_data_d  = (state_q == ERR) ? 8'hEE : 8'h4B;
          cpu_rst_d  = (state_q == LOAD_ACK);
        end else if (i_tx_done) begin
          tx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RUN: begin
        if (i_halt) enter_dump = 1'b1;
        else        cpu_en_d   = 1'b1;
      end
      STEP: enter_dump = 1'b1;
      DUMP_LATCH: begin
        if (word_q == '0)                                   shift_d = i_pc;
        else if (32'(word_q) <= 32'(NUM_REGISTERS))         shift_d = i_reg_data;
        else                                                shift_d = i_mem_data;
        // Present the next word's address now so memory data has settled by its latch.
        if (nxt_w <= 32'(NUM_REGISTERS)) begin
          reg_addr_d = REG_ADDR_W'(nxt_w - 32'd1);
        end
        if (nxt_w > 32'(NUM_REGISTERS) && nxt_w < 32'(TOTAL_WORDS)) begin
          mem_addr_d = DMEM_ADDR_W'(nxt_w - 32'd1 - 32'(NUM_REGISTERS));
        end
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        tx_data_d  = shift_q[7:0];
        tx_start_d = 1'b1;
        state_d    = DUMP_WAIT;
`ifdef DEBUG_UNIT_CKSUM_EN
        cks_d = cks_q ^ shift_q[7:0];
`endif
      end
      DUMP_WAIT: begin
        if (i_tx_done) begin
`ifdef DEBUG_UNIT_CKSUM_EN
          if (cks_phase_q) begin
            state_d = IDLE;
          end else
`endif
          begin
            shift_d = shift_q >> 8;
            if (byte_q == BCW'(BPW - 1)) begin
              byte_d = '0;
              if (32'(word_q) == 32'(TOTAL_WORDS - 1)) begin
`ifdef DEBUG_UNIT_CKSUM_EN
                cks_phase_d = 1'b1;
                shift_d     = {{(SIZE-8){1'b0}}, cks_q};
                state_d     = DUMP_SEND;
`else
                state_d = IDLE;
`endif
              end else begin
                word_d  = word_q + WCW'(1);
                state_d = DUMP_LATCH;
              end
            end else begin
              byte_d  = byte_q + BCW'(1);
              state_d = DUMP_SEND;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_dump) begin
      state_d    = DUMP_LATCH;
      word_d     = '0;
      byte_d     = '0;
      reg_addr_d = '0;
      mem_addr_d = '0;
`ifdef DEBUG_UNIT_CKSUM_EN
      cks_d       = 8'h00;
      cks_phase_d = 1'b0;
`endif
    end
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      word_q      <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      tx_busy_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
`ifdef DEBUG_UNIT_CKSUM_EN
      cks_q       <= 8'h00;
      cks_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      tx_busy_q   <= tx_busy_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_q   <= cpu_rst_d;
      reg_addr_q  <= reg_addr_d;
      mem_addr_q  <= mem_addr_d;
`ifdef DEBUG_UNIT_CKSUM_EN
      cks_q       <= cks_d;
      cks_phase_q <= cks_phase_d;
`endif
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_imem_we   = imem_we_q;
  assign o_imem_addr = imem_addr_q;
  assign o_imem_data = imem_data_q;
  assign o_cpu_en    = cpu_en_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_debug_unit.sv
// Testbench for debug_unit: host byte driver, UART tx responder, core-side
// register/memory model and a byte-stream reference model of load/dump traffic.
module tb_debug_unit;
  localparam int NR   = 32;
  localparam int DW   = 16;
  localparam int MAXI = 64;
`ifdef DEBUG_UNIT_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int DUMP_LEN = 4 * (1 + NR + DW) + CK;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_imem_we;
  logic [5:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_cpu_en;
  logic        o_cpu_rst;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [3:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic [3:0]  o_state;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst), .i_halt(i_halt), .i_pc(i_pc),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_state(o_state)
  );

  // Core-side model: combinational register file, 1-cycle-latency data memory.
  logic [31:0] regs [NR];
  logic [31:0] dmem [DW];
  assign i_reg_data = regs[o_reg_addr];
  always @(posedge clk) i_mem_data <= dmem[o_mem_addr];

  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  logic [37:0] wr_q  [$];
  logic [31:0] imem_seen [MAXI];
  logic [31:0] load_words [MAXI];
  int checks, failures, en_count, rst_count, wr_count;
  bit resp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // UART tx responder: compares each byte against the expected stream, checks hold/pulse rules.
  initial begin : tx_resp
    logic [7:0] b;
    logic [7:0] e;
    int d;
    bit skip;
    i_tx_done = 1'b0;
    skip = 1'b0;
    resp_busy = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (o_tx_start && i_rst) begin
        resp_busy = 1'b1;
        b = o_tx_data;
        got_q.push_back(b);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=%02h required=none", b);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", b, e);
        end
        d = $urandom_range(1, 4);
        for (int k = 0; k < d && i_rst; k++) begin
          @(negedge clk);
          if (i_rst) begin
            check("tx_start_while_busy", o_tx_start, 1'b0);
            check("tx_data_hold", o_tx_data, b);
          end
        end
        if (i_rst) begin
          i_tx_done = 1'b1;
          @(negedge clk);
          i_tx_done = 1'b0;
          skip = 1'b1;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Core-side monitor: imem writes against expected queue, pulse widths, enable cycles.
  initial begin : core_mon
    logic prev_we, prev_rst;
    logic [37:0] w;
    prev_we = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (o_cpu_en) en_count++;
      if (o_cpu_rst) begin
        rst_count++;
        check("cpu_rst_single_cycle", prev_rst, 1'b0);
      end
      if (o_imem_we) begin
        wr_count++;
        check("imem_we_single_cycle", prev_we, 1'b0);
        imem_seen[o_imem_addr] = o_imem_data;
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL imem_write_unexpected actual=%0h:%08h required=none", o_imem_addr, o_imem_data);
        end else begin
          w = wr_q.pop_front();
          check("imem_addr", o_imem_addr, 32'(w[37:32]));
          check("imem_data", o_imem_data, w[31:0]);
        end
      end
      prev_we = o_imem_we;
      prev_rst = o_cpu_rst;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_busy || o_state != 4'd0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++; failures++;
      $display("FAIL %s timeout state=%0d pending=%0d required=idle", name, o_state, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic randomize_core();
    i_pc = $urandom;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    for (int i = 0; i < DW; i++) dmem[i] = $urandom;
  endtask

  // Expected dump: PC, registers, memory window, each word LSB first (+ XOR byte if enabled).
  task automatic push_dump();
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    for (int k = 0; k < 1 + NR + DW; k++) begin
      if (k == 0)       w = i_pc;
      else if (k <= NR) w = regs[k-1];
      else              w = dmem[k-1-NR];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
`ifdef DEBUG_UNIT_CKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic do_load(input int n, input bit bad_ck);
    logic [7:0] x;
    int r0;
    x = 8'h00;
    r0 = rst_count;
    for (int i = 0; i < n; i++) wr_q.push_back({6'(i), load_words[i]});
    exp_q.push_back(bad_ck ? 8'hEE : 8'h4B);
    send_rx(8'h4C);
    send_rx(8'(n));
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) begin
        send_rx(load_words[i][8*b +: 8]);
        x ^= load_words[i][8*b +: 8];
      end
`ifdef DEBUG_UNIT_CKSUM_EN
    send_rx(bad_ck ? ~x : x);
`endif
    wait_idle("load");
    check("load_cpu_rst_pulses", rst_count - r0, bad_ck ? 0 : 1);
    check("load_writes_drained", wr_q.size(), 0);
  endtask

  initial begin : main
    int n, exp_wr, r0;
    logic [7:0] u;
    checks = 0; failures = 0; en_count = 0; rst_count = 0; wr_count = 0; exp_wr = 0;
    i_rst = 1'b0; i_rx_data = 8'h00; i_rx_done = 1'b0; i_halt = 1'b0; i_pc = 32'h0;
    for (int i = 0; i < NR; i++) regs[i] = 32'h0;
    for (int i = 0; i < DW; i++) dmem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_state", o_state, 4'd0);
    check("reset_tx_start", o_tx_start, 1'b0);
    check("reset_tx_data", o_tx_data, 8'h00);
    check("reset_cpu_en", o_cpu_en, 1'b0);
    check("reset_cpu_rst", o_cpu_rst, 1'b0);
    check("reset_imem_we", o_imem_we, 1'b0);
    check("reset_imem_addr", o_imem_addr, 6'd0);
    check("reset_imem_data", o_imem_data, 32'h0);
    check("reset_reg_addr", o_reg_addr, 5'd0);
    check("reset_mem_addr", o_mem_addr, 4'd0);
    @(posedge clk); #1 i_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed load
    load_words[0] = 32'h24010020;
    load_words[1] = 32'hFFFFFFFF;
    do_load(2, 1'b0);
    exp_wr += 2;
    check("load_imem0_literal", imem_seen[0], 32'h24010020);
    check("load_imem1_literal", imem_seen[1], 32'hFFFFFFFF);
    check("load_write_count", wr_count, 2);

    // Rejected word counts
    exp_q.push_back(8'hEE); send_rx(8'h4C); send_rx(8'h00); wait_idle("load_cnt0");
    exp_q.push_back(8'hEE); send_rx(8'h4C); send_rx(8'h41); wait_idle("load_cnt65");
    check("bad_cnt_no_write", wr_count, exp_wr);
    check("bad_cnt_state_idle", o_state, 4'd0);

    // Random loads, last one at full depth
    for (int t = 0; t < 3; t++) begin
      n = (t == 2) ? MAXI : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_words[i] = $urandom;
      do_load(n, 1'b0);
      exp_wr += n;
    end
    check("load_write_total", wr_count, exp_wr);

`ifdef DEBUG_UNIT_CKSUM_EN
    n = 3;
    for (int i = 0; i < n; i++) load_words[i] = $urandom;
    do_load(n, 1'b1);
    exp_wr += n;
    check("bad_cksum_writes_kept", wr_count, exp_wr);
`endif

    // Single step with known core state
    randomize_core();
    i_pc = 32'h4; regs[1] = 32'h20; dmem[0] = 32'hDEADBEEF;
    got_q.delete(); en_count = 0;
    push_dump();
    send_rx(8'h53);
    wait_idle("step");
    check("step_en_cycles", en_count, 1);
    check("step_dump_len", got_q.size(), 196 + CK);
    check("step_pc_b0", got_q[0], 8'h04);
    check("step_pc_b1", got_q[1], 8'h00);
    check("step_pc_b3", got_q[3], 8'h00);
    check("step_reg1_b0", got_q[8], 8'h20);
    check("step_reg1_b1", got_q[9], 8'h00);
    check("step_mem0_b0", got_q[132], 8'hEF);
    check("step_mem0_b1", got_q[133], 8'hBE);
    check("step_mem0_b2", got_q[134], 8'hAD);
    check("step_mem0_b3", got_q[135], 8'hDE);

    // Continuous run, halt after 10 cycles, stray host byte during dump
    randomize_core();
    got_q.delete(); en_count = 0;
    push_dump();
    @(posedge clk); #1; i_rx_data = 8'h43; i_rx_done = 1'b1;
    @(posedge clk); #1; i_rx_done = 1'b0;
    repeat (9) @(posedge clk);
    #1 i_halt = 1'b1;
    n = 0;
    while (got_q.size() < 8 && n < 2000) begin @(negedge clk); n++; end
    send_rx(8'h51);
    wait_idle("run");
    check("run_en_cycles_10_or_11", (en_count == 10 || en_count == 11), 1'b1);
    check("run_dump_len", got_q.size(), DUMP_LEN);

    // Step while already halted: no enable
    randomize_core();
    got_q.delete(); en_count = 0;
    push_dump();
    send_rx(8'h53);
    wait_idle("step_halted");
    check("step_halted_en_cycles", en_count, 0);
    check("step_halted_dump_len", got_q.size(), DUMP_LEN);
    i_halt = 1'b0;

    // Random dump-only commands
    for (int t = 0; t < 2; t++) begin
      randomize_core();
      got_q.delete(); en_count = 0;
      push_dump();
      send_rx(8'h44);
      wait_idle("dump");
      check("dump_len", got_q.size(), DUMP_LEN);
      check("dump_no_enable", en_count, 0);
    end

    // Unknown command bytes
    exp_q.push_back(8'hEE); send_rx(8'h7A); wait_idle("unknown_7a");
    for (int t = 0; t < 5; t++) begin
      u = 8'($urandom_range(0, 255));
      while (u == 8'h4C || u == 8'h43 || u == 8'h53 || u == 8'h44) u = 8'($urandom_range(0, 255));
      exp_q.push_back(8'hEE);
      send_rx(u);
      wait_idle("unknown_rand");
    end

    // Reset in the middle of a dump
    randomize_core();
    got_q.delete();
    push_dump();
    send_rx(8'h44);
    n = 0;
    while (got_q.size() < 20 && n < 5000) begin @(negedge clk); n++; end
    #2 i_rst = 1'b0;
    #1;
    check("midrst_tx_start", o_tx_start, 1'b0);
    check("midrst_state", o_state, 4'd0);
    check("midrst_tx_data", o_tx_data, 8'h00);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 i_rst = 1'b1;
    got_q.delete();
    repeat (30) @(negedge clk);
    check("after_rst_no_bytes", got_q.size(), 0);
    r0 = rst_count;
    randomize_core();
    push_dump();
    send_rx(8'h44);
    wait_idle("dump_after_rst");
    check("dump_after_rst_len", got_q.size(), DUMP_LEN);
    check("dump_after_rst_no_cpu_rst", rst_count, r0);

    repeat (50) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
